// File: rtl/tour_cmd_seq.sv
// Turns a solved knight's tour into robot motion commands: a vertical command
// and then a horizontal command for each stored move, with UART pass-through when idle.
module tour_cmd_seq #(
   parameter int NUM_MOVES = 24,
   parameter int IW        = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_tour,
   output logic [IW-1:0] mv_indx,
   input  logic [7:0]    move,
   input  logic [15:0]   cmd_UART,
   input  logic          cmd_rdy_UART,
   output logic          clr_cmd_rdy_UART,
   output logic [15:0]   cmd,
   output logic          cmd_rdy,
   input  logic          clr_cmd_rdy,
   input  logic          send_resp,
   output logic [7:0]    resp
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      VERT   = 3'd2,
      WAIT_V = 3'd3,
      HORZ   = 3'd4,
      WAIT_H = 3'd5
   } state_t;

   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MOVES - 1);

   localparam logic [3:0] OP_MOVE    = 4'h2;
   localparam logic [3:0] OP_FANFARE = 4'h3;
   localparam logic [7:0] HDG_NORTH  = 8'h00;
   localparam logic [7:0] HDG_SOUTH  = 8'h7F;
   localparam logic [7:0] HDG_EAST   = 8'hBF;
   localparam logic [7:0] HDG_WEST   = 8'h3F;
   localparam logic [7:0] RESP_DONE  = 8'hA5;
   localparam logic [7:0] RESP_BUSY  = 8'h5A;

   state_t        state_q, state_d;
   logic [IW-1:0] mv_indx_q, mv_indx_d;
   logic [7:0]    move_q, move_d;
   logic [5:0]    off_s;

   // Offset packed as {dx_neg, dx_mag[1:0], dy_neg, dy_mag[1:0]}; anything not one-hot is a null move.
   function automatic logic [5:0] decode_offset(input logic [7:0] mv);
      logic [5:0] off;
      case (mv)
         8'h01:   off = {1'b1, 2'd1, 1'b0, 2'd2};
         8'h02:   off = {1'b0, 2'd1, 1'b0, 2'd2};
         8'h04:   off = {1'b1, 2'd2, 1'b0, 2'd1};
         8'h08:   off = {1'b1, 2'd2, 1'b1, 2'd1};
         8'h10:   off = {1'b1, 2'd1, 1'b1, 2'd2};
         8'h20:   off = {1'b0, 2'd1, 1'b1, 2'd2};
         8'h40:   off = {1'b0, 2'd2, 1'b1, 2'd1};
         8'h80:   off = {1'b0, 2'd2, 1'b0, 2'd1};
         default: off = 6'd0;
      endcase
      return off;
   endfunction

   function automatic logic [15:0] vert_cmd(input logic [5:0] off);
      logic [7:0] hdg;
      if (off[2] && (off[1:0] != 2'd0)) begin
         hdg = HDG_SOUTH;
      end else begin
         hdg = HDG_NORTH;
      end
      return {OP_MOVE, hdg, 2'b00, off[1:0]};
   endfunction

   function automatic logic [15:0] horz_cmd(input logic [5:0] off);
      logic [7:0] hdg;
      if (off[4:3] == 2'd0) begin
         hdg = HDG_NORTH;
      end else if (off[5]) begin
         hdg = HDG_WEST;
      end else begin
         hdg = HDG_EAST;
      end
      return {OP_FANFARE, hdg, 2'b00, off[4:3]};
   endfunction

   assign off_s   = decode_offset(move_q);
   assign mv_indx = mv_indx_q;

   // State, move index and latched move registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mv_indx_q <= {IW{1'b0}};
         move_q    <= 8'h00;
      end else begin
         state_q   <= state_d;
         mv_indx_q <= mv_indx_d;
         move_q    <= move_d;
      end
   end

   // Next-state logic; the index only advances once the horizontal leg has been executed.
   always_comb begin
      state_d   = state_q;
      mv_indx_d = mv_indx_q;
      move_d    = move_q;
      case (state_q)
         IDLE: begin
            if (start_tour) begin
               mv_indx_d = {IW{1'b0}};
               state_d   = LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            move_d  = move;
            state_d = VERT;
         end
         VERT: begin
            if (clr_cmd_rdy) begin
               state_d = WAIT_V;
            end else begin
               state_d = VERT;
            end
         end
         WAIT_V: begin
            if (send_resp) begin
               state_d = HORZ;
            end else begin
               state_d = WAIT_V;
            end
         end
         HORZ: begin
            if (clr_cmd_rdy) begin
               state_d = WAIT_H;
            end else begin
               state_d = HORZ;
            end
         end
         WAIT_H: begin
            if (send_resp) begin
               if (mv_indx_q == LAST_IDX) begin
                  state_d = IDLE;
               end else begin
                  mv_indx_d = mv_indx_q + IW'(1);
                  state_d   = LOAD;
               end
            end else begin
               state_d = WAIT_H;
            end
         end
         default: begin
            mv_indx_d = {IW{1'b0}};
            state_d   = IDLE;
         end
      endcase
   end

   // Output decode; cmd_rdy follows state so it drops the cycle after the command is taken.
   always_comb begin
      cmd              = vert_cmd(off_s);
      cmd_rdy          = 1'b0;
      clr_cmd_rdy_UART = 1'b0;
      resp             = RESP_BUSY;
      case (state_q)
         IDLE: begin
            cmd              = cmd_UART;
            cmd_rdy          = cmd_rdy_UART;
            clr_cmd_rdy_UART = clr_cmd_rdy;
            resp             = RESP_DONE;
         end
         LOAD: begin
            cmd_rdy = 1'b0;
         end
         VERT: begin
            cmd_rdy = 1'b1;
         end
         WAIT_V: begin
            cmd_rdy = 1'b0;
         end
         HORZ: begin
            cmd     = horz_cmd(off_s);
            cmd_rdy = 1'b1;
         end
         WAIT_H: begin
            cmd = horz_cmd(off_s);
            if (mv_indx_q == LAST_IDX) begin
               resp = RESP_DONE;
            end else begin
               resp = RESP_BUSY;
            end
         end
         default: begin
            cmd              = cmd_UART;
            cmd_rdy          = cmd_rdy_UART;
            clr_cmd_rdy_UART = clr_cmd_rdy;
            resp             = RESP_DONE;
         end
      endcase
   end

endmodule
